rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port (RFWr/A3/WD) between several writeback requesters: ALU pipe, load unit, multi-cycle mul/div unit.
- Round-robin arbitration with a valid/ready handshake per requester, followed by one registered output stage that drives the register file.
- Provides forwarding hit/data for the two read addresses, so that a write still in the output stage is visible to readers in the same cycle.

---
 rtl/rf_arb_pkg.sv | 22 ++
 rtl/rf_wb_arbiter_if.sv | 43 ++++
 rtl/rr_arbiter.sv | 66 ++++++
 rtl/rf_wb_arbiter.sv | 116 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared constants for the register-file writeback arbiter
//
// Purpose : default geometry of the writeback arbiter, the hard-wired zero
//           register address and the helper that sizes the round-robin pointer.
// Ports   : none (package)
package rf_arb_pkg;

   localparam int NREQ_DEF = 3;
   localparam int AW_DEF   = 5;
   localparam int DW_DEF   = 32;

   // Register 0 is hard-wired; writes to it are acknowledged but dropped.
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Pointer width for a given requester count; never narrower than 1 bit.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int PTR_W_DEF = ptr_w(NREQ_DEF);

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - requester and register-file bus of the writeback arbiter
//
// Purpose : bundles the per-requester valid/ready handshake, the registered
//           register-file write port and the forwarding lookup.
// Signals : wb_stall, req_valid[NREQ], req_addr[NREQ*AW], req_data[NREQ*DW],
//           req_ready[NREQ], RFWr, A3[AW], WD[DW], A1/A2[AW],
//           fwd1_hit/fwd2_hit, fwd1_data/fwd2_data[DW]
// Modports: master - requesters and read stage (drive requests, read results)
//           slave  - the arbiter itself
interface rf_wb_arbiter_if
   import rf_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF
);

   logic               wb_stall;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               RFWr;
   logic [AW-1:0]      A3;
   logic [DW-1:0]      WD;
   logic [AW-1:0]      A1;
   logic [AW-1:0]      A2;
   logic               fwd1_hit;
   logic               fwd2_hit;
   logic [DW-1:0]      fwd1_data;
   logic [DW-1:0]      fwd2_data;

   modport master (
      output wb_stall, req_valid, req_addr, req_data, A1, A2,
      input  req_ready, RFWr, A3, WD, fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
   );

   modport slave (
      input  wb_stall, req_valid, req_addr, req_data, A1, A2,
      output req_ready, RFWr, A3, WD, fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
   );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin (or fixed-priority) grant picker
//
// Purpose : picks at most one requester per cycle. Round-robin searches from
//           ptr_i upward modulo NREQ; with RF_ARB_FIXED_PRIO_EN defined the
//           lowest index wins and ptr_i is ignored.
// Ports   : req_i[NREQ]   request vector
//           ptr_i[PW]     search start index
//           en_i          grant enable (low blocks every grant)
//           gnt_o[NREQ]   one-hot grant, or zero
//           gnt_idx_o[PW] index of the granted requester (0 when none)
//           gnt_any_o     a grant was issued
// Macro   : RF_ARB_FIXED_PRIO_EN
module rr_arbiter
   import rf_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int PW   = ptr_w(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   input  logic            en_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [PW-1:0]   gnt_idx_o,
   output logic            gnt_any_o
);

`ifdef RF_ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr_i;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      gnt_any_o = 1'b0;
      // Walk downward so the lowest requesting index is the last writer.
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (en_i && req_i[i]) begin
            gnt_o     = '0;
            gnt_o[i]  = 1'b1;
            gnt_idx_o = PW'(i);
            gnt_any_o = 1'b1;
         end
      end
   end
`else
   always_comb begin
      int   idx;
      logic found;
      gnt_o     = '0;
      gnt_idx_o = '0;
      gnt_any_o = 1'b0;
      idx       = 0;
      found     = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_i) + k) % NREQ;
         if (en_i && !found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = PW'(idx);
            found      = 1'b1;
         end
      end
      gnt_any_o = found;
   end
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - shares the register-file write port between writeback requesters
//
// Purpose : grants one requester per cycle (round-robin by default), registers
//           the winner into a single output stage that drives RFWr/A3/WD, and
//           forwards the pending stage write to the two read addresses.
// Ports   : clk      rising-edge clock
//           rst      asynchronous reset, active low
//           bus      rf_wb_arbiter_if.slave: wb_stall, req_valid/addr/data,
//                    req_ready, RFWr, A3, WD, A1, A2, fwd1/2_hit, fwd1/2_data
// Macro   : RF_ARB_FIXED_PRIO_EN - fixed priority, no round-robin pointer
module rf_wb_arbiter
   import rf_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF
) (
   input  logic             clk,
   input  logic             rst,
   rf_wb_arbiter_if.slave   bus
);

   localparam int PW = ptr_w(NREQ);

   logic [NREQ-1:0] gnt;
   logic [PW-1:0]   gnt_idx;
   logic            gnt_any;
   logic [PW-1:0]   ptr;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;

   logic            rfwr_q, rfwr_d;
   logic [AW-1:0]   a3_q, a3_d;
   logic [DW-1:0]   wd_q, wd_d;

   // Gating the enable with rst keeps every req_ready low while reset is held,
   // so no requester believes it handed off a write that the stage discards.
   rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
      .req_i     (bus.req_valid),
      .ptr_i     (ptr),
      .en_i      (rst && !bus.wb_stall),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .gnt_any_o (gnt_any)
   );

   assign bus.req_ready = gnt;

`ifdef RF_ARB_FIXED_PRIO_EN
   logic unused_idx;
   assign unused_idx = ^gnt_idx;
   assign ptr        = '0;
`else
   logic [PW-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any) begin
         ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;
`endif

   // AND-OR mux of the winning requester's payload; grant is one-hot or zero.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_addr = sel_addr | bus.req_addr[i*AW +: AW];
            sel_data = sel_data | bus.req_data[i*DW +: DW];
         end
      end
   end

   // A granted write to register 0 is acknowledged but leaves the stage idle,
   // and A3/WD keep their old contents so forwarding never sees register 0.
   always_comb begin
      rfwr_d = gnt_any && (sel_addr != AW'(REG_ZERO));
      a3_d   = rfwr_d ? sel_addr : a3_q;
      wd_d   = rfwr_d ? sel_data : wd_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rfwr_q <= 1'b0;
         a3_q   <= '0;
         wd_q   <= '0;
      end else begin
         rfwr_q <= rfwr_d;
         a3_q   <= a3_d;
         wd_q   <= wd_d;
      end
   end

   assign bus.RFWr = rfwr_q;
   assign bus.A3   = a3_q;
   assign bus.WD   = wd_q;

   // Bypass for readers in the same cycle the stage writes the register file.
   assign bus.fwd1_hit  = rfwr_q && (bus.A1 == a3_q) && (bus.A1 != AW'(REG_ZERO));
   assign bus.fwd2_hit  = rfwr_q && (bus.A2 == a3_q) && (bus.A2 != AW'(REG_ZERO));
   assign bus.fwd1_data = bus.fwd1_hit ? wd_q : '0;
   assign bus.fwd2_data = bus.fwd2_hit ? wd_q : '0;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for the register-file writeback arbiter
module tb_rf_wb_arbiter;

   localparam int NREQ = 3;
   localparam int AW   = 5;
   localparam int DW   = 32;

   typedef struct {
      logic          rfwr;
      logic [AW-1:0] a3;
      logic [DW-1:0] wd;
   } exp_t;

   logic clk;
   logic rst;

   rf_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

   rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   exp_t q[$];

   // Requester-side view: each requester owns at most one outstanding write.
   bit            pend  [NREQ];
   logic [AW-1:0] paddr [NREQ];
   logic [DW-1:0] pdata [NREQ];
   int            gcount[NREQ];

   // Reference model state: where the fair search starts, and what the
   // register-file port should show after the coming edge.
   int            m_ptr;
   logic          m_rfwr;
   logic [AW-1:0] m_a3;
   logic [DW-1:0] m_wd;

   logic [AW-1:0] a1_v, a2_v;
   bit            fa_en;
   logic [AW-1:0] fa1, fa2;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      pend[i]  = 1'b1;
      paddr[i] = a;
      pdata[i] = d;
   endtask

   function automatic logic [AW-1:0] pick_rd(input logic [AW-1:0] stage_a3);
      case ($urandom_range(3))
         0:       return '0;
         1, 2:    return stage_a3;
         default: return AW'($urandom);
      endcase
   endfunction

   // One clock cycle: drive at the falling edge, check the grant and push the
   // expected register-file state for the following rising edge.
   task automatic step(input bit stall, input bit rstv, input int prob);
      exp_t             e;
      int               g;
      logic [NREQ-1:0]  eg;
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
         if (!pend[i] && int'($urandom_range(99)) < prob) begin
            pend[i]  = 1'b1;
            paddr[i] = ($urandom_range(6) == 0) ? '0 : AW'($urandom);
            pdata[i] = $urandom;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         bus.req_valid[i]            = pend[i];
         bus.req_addr[i*AW +: AW]    = paddr[i];
         bus.req_data[i*DW +: DW]    = pdata[i];
      end
      bus.wb_stall = stall;
      rst          = rstv;
      #1;
      g = -1;
      if (rstv && !stall) begin
         for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && pend[idx]) g = idx;
         end
      end
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      check("req_ready", 64'(bus.req_ready), 64'(eg));
      for (int i = 0; i < NREQ; i++) begin
         if (bus.req_ready[i]) gcount[i]++;
      end
      if (!rstv) begin
         check("rst_rfwr", 64'(bus.RFWr), 64'(0));
         check("rst_a3",   64'(bus.A3),   64'(0));
         check("rst_wd",   64'(bus.WD),   64'(0));
         m_ptr  = 0;
         m_rfwr = 1'b0;
         m_a3   = '0;
         m_wd   = '0;
      end else if (g >= 0) begin
         m_ptr = (g + 1) % NREQ;
         if (paddr[g] != 0) begin
            m_rfwr = 1'b1;
            m_a3   = paddr[g];
            m_wd   = pdata[g];
         end else begin
            m_rfwr = 1'b0;
         end
         pend[g] = 1'b0;
      end else begin
         m_rfwr = 1'b0;
      end
      e.rfwr = m_rfwr;
      e.a3   = m_a3;
      e.wd   = m_wd;
      q.push_back(e);
      a1_v   = fa_en ? fa1 : pick_rd(m_a3);
      a2_v   = fa_en ? fa2 : pick_rd(m_a3);
      bus.A1 = a1_v;
      bus.A2 = a2_v;
   endtask

   // Monitor: the stage presents a new state on every rising edge.
   initial begin
      exp_t          e;
      logic          h1, h2;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e  = q.pop_front();
            h1 = e.rfwr && (a1_v == e.a3) && (a1_v != 0);
            h2 = e.rfwr && (a2_v == e.a3) && (a2_v != 0);
            check("RFWr",      64'(bus.RFWr),      64'(e.rfwr));
            check("A3",        64'(bus.A3),        64'(e.a3));
            check("WD",        64'(bus.WD),        64'(e.wd));
            check("fwd1_hit",  64'(bus.fwd1_hit),  64'(h1));
            check("fwd2_hit",  64'(bus.fwd2_hit),  64'(h2));
            check("fwd1_data", 64'(bus.fwd1_data), h1 ? 64'(e.wd) : 64'(0));
            check("fwd2_data", 64'(bus.fwd2_data), h2 ? 64'(e.wd) : 64'(0));
         end
      end
   end

   initial begin
      rst           = 1'b0;
      bus.wb_stall  = 1'b0;
      bus.req_valid = '0;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      bus.A1        = '0;
      bus.A2        = '0;
      a1_v          = '0;
      a2_v          = '0;
      fa_en         = 1'b0;
      fa1           = '0;
      fa2           = '0;
      m_ptr         = 0;
      m_rfwr        = 1'b0;
      m_a3          = '0;
      m_wd          = '0;
      for (int i = 0; i < NREQ; i++) begin
         pend[i]   = 1'b0;
         paddr[i]  = '0;
         pdata[i]  = '0;
         gcount[i] = 0;
      end

      // Reset held, then idle.
      repeat (2) step(1'b0, 1'b0, 0);
      repeat (3) step(1'b0, 1'b1, 0);

      // Everybody valid every cycle: two grants each in six cycles.
      for (int i = 0; i < NREQ; i++) gcount[i] = 0;
      repeat (6) step(1'b0, 1'b1, 100);
      for (int i = 0; i < NREQ; i++) check($sformatf("fair_%0d", i), 64'(gcount[i]), 64'(2));
      repeat (4) step(1'b0, 1'b1, 0);

      // Single request.
      set_req(0, 5'd5, 32'hDEADBEEF);
      repeat (3) step(1'b0, 1'b1, 0);

      // Write to register 0, then a contended grant right after it.
      set_req(1, 5'd0, 32'h1234);
      step(1'b0, 1'b1, 0);
      set_req(0, 5'd9,  32'h0000_0909);
      set_req(2, 5'd11, 32'h0000_0B0B);
      repeat (3) step(1'b0, 1'b1, 0);

      // Stall with a write already in flight.
      set_req(0, 5'd3, 32'h0000_AAAA);
      step(1'b0, 1'b1, 0);
      set_req(1, 5'd4, 32'h0000_BBBB);
      repeat (3) step(1'b1, 1'b1, 0);
      repeat (2) step(1'b0, 1'b1, 0);

      // Forwarding: stage holds r7 = CAFE while A1=7, A2=0.
      fa_en = 1'b1;
      fa1   = 5'd7;
      fa2   = 5'd0;
      set_req(0, 5'd7, 32'h0000_CAFE);
      step(1'b0, 1'b1, 0);
      step(1'b0, 1'b1, 0);
      fa_en = 1'b0;

      // Random traffic with stalls and one reset in the middle.
      for (int n = 0; n < 300; n++) begin
         step(int'($urandom_range(99)) < 15, (n != 150), 40);
      end
      repeat (2) step(1'b0, 1'b1, 0);

      repeat (2) @(posedge clk);
      #2;
      check("queue_drained", 64'(q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
